// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns load-use, branch redirect and memory-busy events into
// per-stage enable/flush controls. Optional perf counters are enabled with `define STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use_stall,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        mem_wb_flush,
    output logic        mem_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        WAIT
    } state_t;

    state_t            state;
    state_t            ret_state;
    state_t            eff_state;
    logic [2:0]        flush_left;
    logic              pend_redirect;
    logic [WAIT_W-1:0] wait_cnt;
    logic              redirect;
    logic              lu_apply;

    // The cycle that leaves WAIT behaves as the state that was frozen.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eff_state = (state == WAIT) ? ret_state : state;
        redirect  = !mem_busy && (branch_taken || pend_redirect);
        lu_apply  = !mem_busy && !redirect && (eff_state == RUN) && load_use_stall;

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;

        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (eff_state == FLUSH) begin
            if_id_flush = 1'b1;
        end else if (lu_apply) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            ret_state     <= RUN;
            flush_left    <= 3'd0;
            pend_redirect <= 1'b0;
            wait_cnt      <= '0;
            mem_timeout   <= 1'b0;
        end else if (mem_busy) begin
            state <= WAIT;
            if (state != WAIT)
                ret_state <= state;
            if (branch_taken)
                pend_redirect <= 1'b1;
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_LAST)
                mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
            if (redirect) begin
                pend_redirect <= 1'b0;
                flush_left    <= FLUSH_LOAD;
                state         <= (FLUSH_CYCLES > 0) ? FLUSH : RUN;
            end else if (eff_state == FLUSH) begin
                flush_left <= flush_left - 3'd1;
                state      <= (flush_left <= 3'd1) ? RUN : FLUSH;
            end else begin
                state <= RUN;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (lu_apply || state == WAIT)
                stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush)
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl (FLUSH_CYCLES=1, MAX_WAIT=4).
// Outputs are compared as one packed vector per cycle at the falling clock edge.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic load_use_stall;
    logic branch_taken;
    logic mem_busy;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_timeout;

    int n_checks = 0;
    int n_fails  = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_timeout}
    localparam logic [7:0] V_RESET  = 8'b0010_1010;
    localparam logic [7:0] V_IDLE   = 8'b1101_0100;
    localparam logic [7:0] V_LU     = 8'b0001_1100;
    localparam logic [7:0] V_REDIR  = 8'b1111_1100;
    localparam logic [7:0] V_FLUSH  = 8'b1111_0100;
    localparam logic [7:0] V_FREEZE = 8'b0000_0010;

    pipeline_stall_ctrl #(
        .FLUSH_CYCLES(1),
        .MAX_WAIT    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_use_stall(load_use_stall),
        .branch_taken  (branch_taken),
        .mem_busy      (mem_busy),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_en      (id_ex_en),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_flush  (mem_wb_flush),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b, expected %b", tag, got[7:0], exp[7:0]);
        end
    endtask

    // Apply inputs just after a rising edge, compare at the falling edge, then advance.
    task automatic step(input string tag, input logic r, input logic lu, input logic bt,
                        input logic mb, input logic [7:0] exp);
        rst            = r;
        load_use_stall = lu;
        branch_taken   = bt;
        mem_busy       = mb;
        @(negedge clk);
        check(tag, {24'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                    ex_mem_en, mem_wb_flush, mem_timeout}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load_use_stall = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;
        step("reset_hold",        1, 0, 0, 0, V_RESET);
        step("idle_after_reset",  0, 0, 0, 0, V_IDLE);

        step("lu_stall_1",        0, 1, 0, 0, V_LU);
        step("lu_stall_2",        0, 1, 0, 0, V_LU);
        step("lu_release",        0, 0, 0, 0, V_IDLE);

        step("branch_redirect",   0, 0, 1, 0, V_REDIR);
        step("branch_flush",      0, 0, 0, 0, V_FLUSH);
        step("branch_back_run",   0, 0, 0, 0, V_IDLE);

        step("br_lu_same_cycle",  0, 1, 1, 0, V_REDIR);
        step("lu_ignored_flush",  0, 1, 0, 0, V_FLUSH);
        step("lu_after_flush",    0, 1, 0, 0, V_LU);

        step("redir_run",         0, 0, 1, 0, V_REDIR);
        step("redir_in_flush",    0, 0, 1, 0, V_REDIR);
        step("reload_flush",      0, 0, 0, 0, V_FLUSH);
        step("reload_back_run",   0, 0, 0, 0, V_IDLE);

        step("busy_c1",           0, 0, 0, 1, V_FREEZE);
        step("busy_c2_branch",    0, 0, 1, 1, V_FREEZE);
        step("busy_c3",           0, 0, 0, 1, V_FREEZE);
        step("pending_redirect",  0, 0, 0, 0, V_REDIR);
        step("pending_flush",     0, 0, 0, 0, V_FLUSH);
        step("pending_back_run",  0, 0, 0, 0, V_IDLE);

        step("flush_pre_busy",    0, 0, 1, 0, V_REDIR);
        step("busy_in_flush",     0, 0, 0, 1, V_FREEZE);
        step("resume_flush",      0, 0, 0, 0, V_FLUSH);
        step("resume_back_run",   0, 0, 0, 0, V_IDLE);

        step("busy_short",        0, 0, 0, 1, V_FREEZE);
        step("lu_on_wait_exit",   0, 1, 0, 0, V_LU);
        step("idle_after_wait",   0, 0, 0, 0, V_IDLE);

        step("tmo_busy_1",        0, 0, 0, 1, V_FREEZE);
        step("tmo_busy_2",        0, 0, 0, 1, V_FREEZE);
        step("tmo_busy_3",        0, 0, 0, 1, V_FREEZE);
        step("tmo_busy_4",        0, 0, 0, 1, V_FREEZE);
        step("tmo_busy_5",        0, 0, 0, 1, V_FREEZE | 8'd1);
        step("tmo_busy_6",        0, 0, 0, 1, V_FREEZE | 8'd1);
        step("tmo_sticky_1",      0, 0, 0, 0, V_IDLE | 8'd1);
        step("tmo_sticky_2",      0, 0, 0, 0, V_IDLE | 8'd1);

        step("redir_before_rst",  0, 0, 1, 0, V_REDIR | 8'd1);
        step("rst_mid_flush",     1, 0, 0, 0, V_RESET);
        step("run_after_rst",     0, 0, 0, 0, V_IDLE);
        step("run_after_rst_2",   0, 0, 0, 0, V_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
